// File: rtl/alarm_clock_pkg.sv
// Shared types and constants for the alarm clock sequencer.
package alarm_clock_pkg;

  typedef enum logic [2:0] {
    SHOW_TIME,
    SHOW_ALARM,
    KEY_STORED,
    KEY_WAITED,
    KEY_ENTRY,
    SET_ALARM_TIME,
    SET_CURRENT_TIME,
    TIMED_OUT
  } state_t;

  localparam logic [3:0] NOKEY = 4'hA;
  localparam int DEFAULT_TIMEOUT_SEC = 10;

  // True in the states where the keypad inactivity timer is running.
  function automatic logic entry_pending(input state_t s);
    return (s == KEY_WAITED) || (s == KEY_ENTRY);
  endfunction

endpackage

// File: rtl/entry_timeout_counter.sv
// Counts one_second ticks during key entry; saturates and flags expiry at TIMEOUT_SEC.
module entry_timeout_counter
  import alarm_clock_pkg::*;
#(
  parameter int TIMEOUT_SEC = DEFAULT_TIMEOUT_SEC
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  input  logic one_second,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_SEC + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_SEC);

  logic [W-1:0] count_reg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && one_second && (count_reg != LIMIT)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (count_reg == LIMIT);

endmodule

// File: rtl/alarm_clock_fsm.sv
// Alarm clock sequencer: button/keypad decode, display select and load/shift strobes.
module alarm_clock_fsm #(
  parameter int         TIMEOUT_SEC = alarm_clock_pkg::DEFAULT_TIMEOUT_SEC,
  parameter logic [3:0] NOKEY       = alarm_clock_pkg::NOKEY
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic       alarm_button,
  input  logic       time_button,
  input  logic [3:0] key,
  output logic       show_a,
  output logic       show_current_time,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       shift,
  output logic       timeout_err
);

  import alarm_clock_pkg::*;

  state_t state_reg;
  state_t state_next;
  logic   timer_enable;
  logic   expired;

  assign timer_enable = entry_pending(state_reg);

  entry_timeout_counter #(
    .TIMEOUT_SEC(TIMEOUT_SEC)
  ) u_timeout (
    .clock     (clock),
    .reset     (reset),
    .enable    (timer_enable),
    .clear     (!timer_enable),
    .one_second(one_second),
    .expired   (expired)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg <= SHOW_TIME;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SHOW_TIME: begin
        if (alarm_button)       state_next = SHOW_ALARM;
        else if (key != NOKEY)  state_next = KEY_STORED;
      end
      SHOW_ALARM: begin
        if (!alarm_button)      state_next = SHOW_TIME;
      end
      KEY_STORED:               state_next = KEY_WAITED;
      KEY_WAITED: begin
        // A key still held past the timeout does not keep the entry alive.
        if (expired)            state_next = TIMED_OUT;
        else if (key == NOKEY)  state_next = KEY_ENTRY;
      end
      KEY_ENTRY: begin
        if (alarm_button)       state_next = SET_ALARM_TIME;
        else if (time_button)   state_next = SET_CURRENT_TIME;
        else if (key != NOKEY)  state_next = KEY_STORED;
        else if (expired)       state_next = TIMED_OUT;
      end
      SET_ALARM_TIME,
      SET_CURRENT_TIME,
      TIMED_OUT:                state_next = SHOW_TIME;
      default:                  state_next = SHOW_TIME;
    endcase
  end

  // Moore decode, forced quiet while reset is held.
  always_comb begin
    show_a            = 1'b0;
    show_current_time = 1'b0;
    load_new_a        = 1'b0;
    load_new_c        = 1'b0;
    shift             = 1'b0;
    timeout_err       = 1'b0;
    if (reset) begin
      case (state_reg)
        SHOW_ALARM:       show_a = 1'b1;
        KEY_STORED: begin
          shift             = 1'b1;
          show_current_time = 1'b1;
        end
        KEY_WAITED,
        KEY_ENTRY:        show_current_time = 1'b1;
        SET_ALARM_TIME:   load_new_a = 1'b1;
        SET_CURRENT_TIME: load_new_c = 1'b1;
        TIMED_OUT:        timeout_err = 1'b1;
        default:          ;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_clock_fsm.sv
// Self-checking bench for alarm_clock_fsm: vector tables plus timeout/reset sequences.
module tb_alarm_clock_fsm;
  import alarm_clock_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       one_second = 1'b0;
  logic       alarm_button = 1'b0;
  logic       time_button = 1'b0;
  logic [3:0] key = NOKEY;
  logic       show_a, show_current_time, load_new_a, load_new_c, shift, timeout_err;

  alarm_clock_fsm dut (
    .clock            (clock),
    .reset            (reset),
    .one_second       (one_second),
    .alarm_button     (alarm_button),
    .time_button      (time_button),
    .key              (key),
    .show_a           (show_a),
    .show_current_time(show_current_time),
    .load_new_a       (load_new_a),
    .load_new_c       (load_new_c),
    .shift            (shift),
    .timeout_err      (timeout_err)
  );

  always #5 clock = ~clock;

  // Output vector order: {show_a, show_current_time, load_new_a, load_new_c, shift, timeout_err}
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] SA   = 6'b100000;
  localparam logic [5:0] SCT  = 6'b010000;
  localparam logic [5:0] LA   = 6'b001000;
  localparam logic [5:0] LC   = 6'b000100;
  localparam logic [5:0] SH   = 6'b000010;
  localparam logic [5:0] TO   = 6'b000001;

  typedef struct {
    logic       rst_n;
    logic       ab;
    logic       tbtn;
    logic       tick;
    logic [3:0] k;
    logic [5:0] exp;
    string      name;
  } vec_t;

  typedef struct {
    string      name;
    logic [5:0] exp;
  } sb_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];
  sb_t  sb_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   shift_seen = 0;

  wire [5:0] outs = {show_a, show_current_time, load_new_a, load_new_c, shift, timeout_err};

  function automatic vec_t mk(input logic rst_n, input logic ab, input logic tbtn,
                              input logic tick, input logic [3:0] k,
                              input logic [5:0] exp, input string name);
    vec_t v;
    v.rst_n = rst_n; v.ab = ab; v.tbtn = tbtn; v.tick = tick;
    v.k = k; v.exp = exp; v.name = name;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    sb_t        e;
    sb_t        got_e;
    logic [5:0] got;
    @(negedge clock);
    reset        = v.rst_n;
    alarm_button = v.ab;
    time_button  = v.tbtn;
    one_second   = v.tick;
    key          = v.k;
    e.name = v.name;
    e.exp  = v.exp;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    got   = outs;
    got_e = sb_q.pop_front();
    compared++;
    if (got[1]) shift_seen++;
    if (got !== got_e.exp) begin
      mismatched++;
      $display("FAIL %s: outputs=%b required=%b", got_e.name, got, got_e.exp);
    end else begin
      $display("ok   %s: outputs=%b", got_e.name, got);
    end
  endtask

  task automatic step(input logic rst_n, input logic ab, input logic tbtn, input logic tick,
                      input logic [3:0] k, input logic [5:0] exp, input string name);
    apply(mk(rst_n, ab, tbtn, tick, k, exp, name));
  endtask

  task automatic enter_key(input logic [3:0] k, input string tag);
    step(1, 0, 0, 0, k,     SCT | SH, {tag, "_store"});
    step(1, 0, 0, 0, NOKEY, SCT,      {tag, "_wait"});
    step(1, 0, 0, 0, NOKEY, SCT,      {tag, "_entry"});
  endtask

  initial begin
    // Reset, then four-digit entry closed by the time button
    for (int i = 0; i < 3; i++) tbl_a.push_back(mk(0, 1, 0, 0, 4'd5, NONE, $sformatf("rst_hold%0d", i)));
    for (int i = 0; i < 2; i++) tbl_a.push_back(mk(1, 0, 0, 0, NOKEY, NONE, $sformatf("rst_idle%0d", i)));
    for (int d = 1; d <= 4; d++) begin
      tbl_a.push_back(mk(1, 0, 0, 0, 4'(d), SCT | SH, $sformatf("dig%0d_store", d)));
      tbl_a.push_back(mk(1, 0, 0, 0, 4'(d), SCT,      $sformatf("dig%0d_held", d)));
      tbl_a.push_back(mk(1, 0, 0, 0, NOKEY, SCT,      $sformatf("dig%0d_release", d)));
    end
    tbl_a.push_back(mk(1, 0, 1, 0, NOKEY, LC,   "set_time"));
    tbl_a.push_back(mk(1, 0, 0, 0, NOKEY, NONE, "set_time_home"));
    tbl_a.push_back(mk(1, 0, 0, 0, NOKEY, NONE, "set_time_idle"));

    // Alarm display with a key pressed during the hold, then set alarm with both buttons
    tbl_b.push_back(mk(1, 1, 0, 0, NOKEY, SA,   "alm_hold1"));
    tbl_b.push_back(mk(1, 1, 0, 0, 4'd7,  SA,   "alm_hold2_key7"));
    tbl_b.push_back(mk(1, 1, 0, 0, 4'd7,  SA,   "alm_hold3_key7"));
    tbl_b.push_back(mk(1, 1, 0, 0, NOKEY, SA,   "alm_hold4"));
    tbl_b.push_back(mk(1, 1, 0, 0, NOKEY, SA,   "alm_hold5"));
    tbl_b.push_back(mk(1, 0, 0, 0, NOKEY, NONE, "alm_release"));
    tbl_b.push_back(mk(1, 0, 0, 0, NOKEY, NONE, "alm_idle"));
    tbl_b.push_back(mk(1, 0, 0, 0, 4'd9,  SCT | SH, "sa_store"));
    tbl_b.push_back(mk(1, 0, 0, 0, NOKEY, SCT,  "sa_wait"));
    tbl_b.push_back(mk(1, 0, 0, 0, NOKEY, SCT,  "sa_entry"));
    tbl_b.push_back(mk(1, 1, 1, 0, NOKEY, LA,   "sa_both_buttons"));
    tbl_b.push_back(mk(1, 0, 0, 0, NOKEY, NONE, "sa_home"));
    tbl_b.push_back(mk(1, 0, 0, 0, NOKEY, NONE, "sa_idle"));

    // Outputs must be quiet before the first edge while reset is low
    #2;
    compared++;
    if (outs !== NONE) begin
      mismatched++;
      $display("FAIL pre_edge_reset: outputs=%b required=%b", outs, NONE);
    end

    for (int i = 0; i < tbl_a.size(); i++) apply(tbl_a[i]);
    compared++;
    if (shift_seen != 4) begin
      mismatched++;
      $display("FAIL entry_shift_count: shifts=%0d required=4", shift_seen);
    end
    for (int i = 0; i < tbl_b.size(); i++) apply(tbl_b[i]);

    // Plain timeout in KEY_ENTRY
    enter_key(4'd3, "to1");
    for (int i = 1; i <= 10; i++) begin
      step(1, 0, 0, 1, NOKEY, SCT, $sformatf("to1_tick%0d", i));
      step(1, 0, 0, 0, NOKEY, (i == 10) ? TO : SCT, $sformatf("to1_gap%0d", i));
    end
    step(1, 0, 0, 0, NOKEY, NONE, "to1_home");

    // Key on the 9th tick restarts the count; 10 fresh ticks are needed
    enter_key(4'd3, "to2");
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 0, 1, NOKEY, SCT, $sformatf("to2_tick%0d", i));
      step(1, 0, 0, 0, NOKEY, SCT, $sformatf("to2_gap%0d", i));
    end
    step(1, 0, 0, 1, 4'd4,  SCT | SH, "to2_key_on_tick9");
    step(1, 0, 0, 0, 4'd4,  SCT, "to2_wait");
    step(1, 0, 0, 0, NOKEY, SCT, "to2_entry");
    for (int i = 1; i <= 10; i++) begin
      step(1, 0, 0, 1, NOKEY, SCT, $sformatf("to2_fresh_tick%0d", i));
      step(1, 0, 0, 0, NOKEY, (i == 10) ? TO : SCT, $sformatf("to2_fresh_gap%0d", i));
    end
    step(1, 0, 0, 0, NOKEY, NONE, "to2_home");

    // Key held in KEY_WAITED until timeout
    step(1, 0, 0, 0, 4'd6, SCT | SH, "held_store");
    step(1, 0, 0, 0, 4'd6, SCT,      "held_wait");
    for (int i = 1; i <= 10; i++) begin
      step(1, 0, 0, 1, 4'd6, SCT, $sformatf("held_tick%0d", i));
      step(1, 0, 0, 0, 4'd6, (i == 10) ? TO : SCT, $sformatf("held_gap%0d", i));
    end
    step(1, 0, 0, 1, 4'd6,  NONE, "held_tick11_home");
    step(1, 0, 0, 1, NOKEY, NONE, "held_tick12_idle");

    // Reset while in KEY_ENTRY with both buttons pressed
    enter_key(4'd2, "rst_mid");
    step(0, 1, 1, 0, NOKEY, NONE, "rst_mid_assert1");
    step(0, 1, 1, 0, NOKEY, NONE, "rst_mid_assert2");
    step(1, 0, 0, 0, NOKEY, NONE, "rst_mid_release1");
    step(1, 0, 0, 0, NOKEY, NONE, "rst_mid_release2");

    compared++;
    if (sb_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: pending=%0d required=0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alarm_clock_fsm.md
Name: alarm_clock_fsm

Overview:
- Central sequencer for the four-digit alarm clock.
- Decodes the alarm and time buttons and the keypad code, and drives the display-select strobes consumed by the four-digit LCD driver (show_a, show_current_time).
- Issues load strobes to the alarm register, load strobes to the time counter, and shift strobes to the key-entry register.
- Abandons key entry after a keypad inactivity timeout.

Parameters:
- TIMEOUT_SEC, 10, number of one_second ticks without key activity before entry is abandoned (>=1).
- NOKEY, 4'hA, keypad code meaning "no key pressed".

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-low reset.
- one_second  input  1  single-cycle tick, once per second.
- alarm_button  input  1  level, high while alarm button held.
- time_button  input  1  level, high while time button held.
- key  input  4  keypad code, 0-9 digit, NOKEY when idle.
- show_a  output  1  display alarm time on LCD.
- show_current_time  output  1  display key-entry buffer (new time) on LCD.
- load_new_a  output  1  one-cycle strobe: copy key buffer into alarm register.
- load_new_c  output  1  one-cycle strobe: copy key buffer into time counter.
- shift  output  1  one-cycle strobe: shift current key into key buffer.
- timeout_err  output  1  one-cycle strobe: entry abandoned by timeout.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - reset low at a rising edge forces state to SHOW_TIME and timeout counter to 0.
  - While reset is low and on the cycle after it, all outputs are 0.
  - Reset mid-entry discards the entry; no load strobe is issued.
- Output timing:
  - Outputs are Moore, decoded from the state register.
  - A strobe appears in the first cycle the corresponding state is held, and lasts exactly one cycle.
- States and transitions (evaluated each edge; priority listed top to bottom):
  - SHOW_TIME (all outputs 0):
    - alarm_button -> SHOW_ALARM.
    - key != NOKEY -> KEY_STORED.
    - else stay.
  - SHOW_ALARM (show_a=1):
    - alarm_button low -> SHOW_TIME.
    - else stay.
    - key is ignored.
  - KEY_STORED (shift=1, show_current_time=1):
    - unconditionally -> KEY_WAITED.
    - timeout counter cleared.
  - KEY_WAITED (show_current_time=1):
    - timeout reached -> SHOW_TIME via TIMED_OUT.
    - key == NOKEY -> KEY_ENTRY.
    - else stay (key still held; no repeat shift).
  - KEY_ENTRY (show_current_time=1):
    - alarm_button -> SET_ALARM_TIME.
    - time_button -> SET_CURRENT_TIME.
    - key != NOKEY -> KEY_STORED.
    - timeout reached -> TIMED_OUT.
    - else stay.
  - SET_ALARM_TIME (load_new_a=1): -> SHOW_TIME.
  - SET_CURRENT_TIME (load_new_c=1): -> SHOW_TIME.
  - TIMED_OUT (timeout_err=1): -> SHOW_TIME.
- Timeout counter:
  - Width $clog2(TIMEOUT_SEC+1).
  - Increments on one_second only in KEY_WAITED and KEY_ENTRY.
  - Cleared in every other state.
  - Saturates at TIMEOUT_SEC.
  - "Timeout reached" means count == TIMEOUT_SEC.
- Simultaneous events:
  - alarm_button and time_button both high in KEY_ENTRY: alarm wins.
  - A button or key on the same edge as the final tick: the button/key wins, and the counter is cleared on leaving.
- Encodings: no illegal state is reachable; the default branch returns to SHOW_TIME.

Decomposition:
- Package alarm_clock_pkg holds:
  - state enum state_t (SHOW_TIME, SHOW_ALARM, KEY_STORED, KEY_WAITED, KEY_ENTRY, SET_ALARM_TIME, SET_CURRENT_TIME, TIMED_OUT).
  - NOKEY constant.
  - default TIMEOUT_SEC.
- One sub-module: entry_timeout_counter.
  - Inputs: clock, reset, enable, clear, one_second.
  - Output: expired.
- The state register, next-state logic and output decode stay in alarm_clock_fsm.

Test Plan:
- Reset: hold reset=0 for 3 cycles with key=5, alarm_button=1 -> all outputs 0; state SHOW_TIME after release, stays there until inputs change.
- Key entry and set time:
  - Stimulus: key=1 (2 cycles), NOKEY, key=2, NOKEY, key=3, NOKEY, key=4, NOKEY, then time_button for 1 cycle.
  - Required: exactly 4 shift pulses, show_current_time high throughout, one load_new_c pulse, then SHOW_TIME with all outputs 0.
- Alarm display: alarm_button held 5 cycles in SHOW_TIME -> show_a=1 from the 2nd to the 6th edge, and 0 the cycle after release; key=7 during hold gives no shift.
- Set alarm:
  - Stimulus: key=9, release, then alarm_button and time_button high in the same cycle.
  - Required: single load_new_a pulse, no load_new_c.
- Timeout:
  - Stimulus: key=3, release, then 10 one_second ticks with no key.
  - Required: timeout_err pulse in the cycle after the 10th tick is registered, then SHOW_TIME; no load strobe.
  - Repeat with key=4 at the 9th tick: counter clears, no timeout, and 10 fresh ticks are required.
- Held key plus reset: key=6 held across 12 ticks in KEY_WAITED -> timeout_err after the 10th tick; assert reset mid-KEY_ENTRY -> return to SHOW_TIME with no strobes.
